// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the fetch PC, issues one imem request at a time and
// queues returned words with their PC in a small circular buffer for decode.
// Optional build macro: IFETCH_MISALIGN_TRAP_EN adds the fetch_misaligned
// output and halts fetch on a misaligned redirect target.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IBUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic        fetch_misaligned
`endif
);

   localparam int PTR_W = $clog2(IBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t             state_reg, state_next;
   logic [31:0]        fetch_pc_reg;
   logic [31:0]        req_pc_reg;      // address of the request in flight
   logic [PTR_W-1:0]   head_reg, tail_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [31:0]        data_mem [IBUF_DEPTH];
   logic [31:0]        pc_mem   [IBUF_DEPTH];

   logic               req_fire;
   logic               push;
   logic               pop;
   logic               halted;
   logic [31:0]        target_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic               trap_reg;

   // Sticky misalignment flag: set by a misaligned redirect, cleared by an aligned one.
   always_ff @(posedge clk) begin
      if (rst) begin
         trap_reg <= 1'b0;
      end else if (redirect_valid) begin
         trap_reg <= (redirect_pc[1:0] != 2'b00);
      end
   end

   assign halted           = trap_reg;
   assign fetch_misaligned = trap_reg;
   assign target_pc        = redirect_pc;      // held as-is so the faulting PC is visible
`else
   assign halted    = 1'b0;
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

   // Request is held off during reset so the first one appears the cycle after release.
   assign imem_req_valid = !rst && !halted && (state_reg == S_REQ)
                           && (count_reg < CNT_W'(IBUF_DEPTH));
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response racing a redirect is stale and never enters the buffer.
   assign push       = (state_reg == S_WAIT) && imem_rsp_valid && !redirect_valid;
   assign inst_valid = (count_reg != '0);
   assign pop        = inst_valid && inst_ready;
   assign inst_data  = inst_valid ? data_mem[head_reg] : 32'h0;
   assign inst_pc    = inst_valid ? pc_mem[head_reg]   : 32'h0;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_REQ;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: track the single outstanding request and whether its data is wanted.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_REQ: begin
            if (req_fire) begin
               state_next = redirect_valid ? S_DRAIN : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_next = S_REQ;
            end else if (redirect_valid) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The stale response retires the outstanding request; a redirect in the
            // same cycle has nothing left to drain, so fetch resumes.
            if (imem_rsp_valid) begin
               state_next = S_REQ;
            end
         end
         default: state_next = S_REQ;
      endcase
   end

   // Fetch PC, in-flight address and buffer pointers; redirect flushes the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= RESET_PC;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
      end else begin
         if (req_fire) begin
            req_pc_reg <= fetch_pc_reg;
         end
         if (redirect_valid) begin
            fetch_pc_reg <= target_pc;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            if (push) begin
               tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
               head_reg <= head_reg + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count_reg <= count_reg + CNT_W'(1);
               2'b01:   count_reg <= count_reg - CNT_W'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   // Buffer storage: one write port per entry, selected by the tail pointer.
   generate
      for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_entry
         // Capture the returned word and the address it was fetched from.
         always_ff @(posedge clk) begin
            if (push && (tail_reg == PTR_W'(gi))) begin
               data_mem[gi] <= imem_rsp_data;
               pc_mem[gi]   <= req_pc_reg;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: cycle-by-cycle vector table for ifetch_unit (IBUF_DEPTH=2,
// RESET_PC=0), plus a hand-written stalled-request sequence.
// Honours IFETCH_MISALIGN_TRAP_EN for the misaligned-redirect expectations.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   int total = 0;
   int bad   = 0;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .IBUF_DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        chk;
      logic        rst;
      logic        rdv;
      logic [31:0] rdpc;
      logic        rqr;
      logic        rsv;
      logic [31:0] rsd;
      logic        ir;
      logic        e_rqv;
      logic [31:0] e_rqa;
      logic        e_iv;
      logic [31:0] e_ipc;
      logic [31:0] e_idat;
      logic        e_mis;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] D0   = 32'h1300_0000;
   localparam logic [31:0] D4   = 32'h1300_0004;
   localparam logic [31:0] D8   = 32'h1300_0008;
   localparam logic [31:0] D100 = 32'h1300_0100;
   localparam logic [31:0] D200 = 32'h1300_0200;

   // One cycle: inputs applied this cycle and the outputs expected before the next edge.
   task automatic add(input string nm, input int r, input int rdv, input int rdpc,
                      input int rqr, input int rsv, input int rsd, input int ir,
                      input int erqv, input int erqa, input int eiv, input int eipc,
                      input int eidat, input int emis);
      vec_t v;
      v.name = nm;    v.chk = 1'b1;
      v.rst = (r != 0); v.rdv = (rdv != 0); v.rdpc = rdpc;
      v.rqr = (rqr != 0); v.rsv = (rsv != 0); v.rsd = rsd; v.ir = (ir != 0);
      v.e_rqv = (erqv != 0); v.e_rqa = erqa; v.e_iv = (eiv != 0);
      v.e_ipc = eipc; v.e_idat = eidat; v.e_mis = (emis != 0);
      vecs.push_back(v);
   endtask

   // Two reset cycles; only the second is checked, once the registers have cleared.
   task automatic add_reset(input string nm);
      add(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[vecs.size()-1].chk = 1'b0;
      add(nm, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check(input string nm, input int row, input string what,
                        input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s row %0d %s: got %h want %h", nm, row, what, got, want);
      end
   endtask

   task automatic drive_idle();
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      inst_ready = 1'b0;
   endtask

   initial begin
      // ---------------- vector table ----------------
      //      name  rst rdv rdpc          rqr rsv rsd           ir   rqv rqa           iv ipc           idat          mis
      add_reset("t1");
      add("t1", 0, 0, 0,            1, 0, 0,            1,   1, 0,            0, 0,            0,            0);
      add("t1", 0, 0, 0,            0, 1, D0,           1,   0, 0,            0, 0,            0,            0);
      add("t1", 0, 0, 0,            1, 0, 0,            1,   1, 4,            1, 0,            D0,           0);
      add("t1", 0, 0, 0,            0, 1, D4,           1,   0, 0,            0, 0,            0,            0);
      add("t1", 0, 0, 0,            1, 0, 0,            1,   1, 8,            1, 4,            D4,           0);
      add("t1", 0, 0, 0,            0, 1, D8,           1,   0, 0,            0, 0,            0,            0);
      add("t1", 0, 0, 0,            0, 0, 0,            1,   1, 12,           1, 8,            D8,           0);

      add_reset("t2");
      add("t2", 0, 0, 0,            1, 0, 0,            0,   1, 0,            0, 0,            0,            0);
      add("t2", 0, 0, 0,            0, 1, D0,           0,   0, 0,            0, 0,            0,            0);
      add("t2", 0, 0, 0,            1, 0, 0,            0,   1, 4,            1, 0,            D0,           0);
      add("t2", 0, 0, 0,            0, 1, D4,           0,   0, 0,            1, 0,            D0,           0);
      add("t2", 0, 0, 0,            1, 0, 0,            0,   0, 0,            1, 0,            D0,           0);
      add("t2", 0, 0, 0,            1, 0, 0,            1,   0, 0,            1, 0,            D0,           0);
      add("t2", 0, 0, 0,            1, 0, 0,            0,   1, 8,            1, 4,            D4,           0);
      add("t2", 0, 0, 0,            0, 1, D8,           1,   0, 0,            1, 4,            D4,           0);
      add("t2", 0, 0, 0,            0, 0, 0,            1,   1, 12,           1, 8,            D8,           0);
      add("t2", 0, 0, 0,            0, 0, 0,            0,   1, 12,           0, 0,            0,            0);

      add_reset("t3");
      add("t3", 0, 0, 0,            1, 0, 0,            0,   1, 0,            0, 0,            0,            0);
      add("t3", 0, 0, 0,            0, 1, D0,           0,   0, 0,            0, 0,            0,            0);
      add("t3", 0, 0, 0,            1, 0, 0,            0,   1, 4,            1, 0,            D0,           0);
      add("t3", 0, 0, 0,            0, 1, D4,           0,   0, 0,            1, 0,            D0,           0);
      add("t3", 0, 0, 0,            0, 0, 0,            1,   0, 0,            1, 0,            D0,           0);
      add("t3", 0, 1, 32'h100,      1, 0, 0,            0,   1, 8,            1, 4,            D4,           0);
      add("t3", 0, 0, 0,            0, 1, D8,           0,   0, 0,            0, 0,            0,            0);
      add("t3", 0, 0, 0,            1, 0, 0,            0,   1, 32'h100,      0, 0,            0,            0);
      add("t3", 0, 0, 0,            0, 1, D100,         0,   0, 0,            0, 0,            0,            0);
      add("t3", 0, 0, 0,            0, 0, 0,            0,   1, 32'h104,      1, 32'h100,      D100,         0);

      add_reset("t4");
      add("t4", 0, 0, 0,            1, 0, 0,            1,   1, 0,            0, 0,            0,            0);
      add("t4", 0, 1, 32'h200,      0, 1, D0,           1,   0, 0,            0, 0,            0,            0);
      add("t4", 0, 0, 0,            1, 0, 0,            1,   1, 32'h200,      0, 0,            0,            0);
      add("t4", 0, 0, 0,            0, 1, D200,         1,   0, 0,            0, 0,            0,            0);
      add("t4", 0, 0, 0,            0, 0, 0,            1,   1, 32'h204,      1, 32'h200,      D200,         0);

      add_reset("t5");
      add("t5", 0, 0, 0,            1, 0, 0,            1,   1, 0,            0, 0,            0,            0);
      add("t5", 1, 0, 0,            0, 0, 0,            1,   0, 0,            0, 0,            0,            0);
      add("t5", 0, 0, 0,            0, 1, 32'hBAD0BAD0, 1,   1, 0,            0, 0,            0,            0);
      add("t5", 0, 0, 0,            1, 0, 0,            1,   1, 0,            0, 0,            0,            0);
      add("t5", 0, 0, 0,            0, 1, D0,           1,   0, 0,            0, 0,            0,            0);
      add("t5", 0, 0, 0,            0, 0, 0,            1,   1, 4,            1, 0,            D0,           0);

      add_reset("t6");
      add("t6", 0, 1, 32'h102,      0, 0, 0,            1,   1, 0,            0, 0,            0,            0);
`ifdef IFETCH_MISALIGN_TRAP_EN
      add("t6", 0, 0, 0,            1, 0, 0,            1,   0, 0,            0, 0,            0,            1);
      add("t6", 0, 0, 0,            0, 1, D100,         1,   0, 0,            0, 0,            0,            1);
      add("t6", 0, 1, 32'h200,      0, 0, 0,            1,   0, 0,            0, 0,            0,            1);
`else
      add("t6", 0, 0, 0,            1, 0, 0,            1,   1, 32'h100,      0, 0,            0,            0);
      add("t6", 0, 0, 0,            0, 1, D100,         1,   0, 0,            0, 0,            0,            0);
      add("t6", 0, 1, 32'h200,      0, 0, 0,            1,   1, 32'h104,      1, 32'h100,      D100,         0);
`endif
      add("t6", 0, 0, 0,            0, 0, 0,            1,   1, 32'h200,      0, 0,            0,            0);

      add_reset("t7");
      add("t7", 0, 1, 32'hFFFFFFFC, 0, 0, 0,            1,   1, 0,            0, 0,            0,            0);
      add("t7", 0, 0, 0,            1, 0, 0,            1,   1, 32'hFFFFFFFC, 0, 0,            0,            0);
      add("t7", 0, 0, 0,            0, 1, 32'h11111111, 1,   0, 0,            0, 0,            0,            0);
      add("t7", 0, 0, 0,            0, 0, 0,            1,   1, 0,            1, 32'hFFFFFFFC, 32'h11111111, 0);

      // ---------------- apply the table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         rst            = vecs[i].rst;
         redirect_valid = vecs[i].rdv;
         redirect_pc    = vecs[i].rdpc;
         imem_req_ready = vecs[i].rqr;
         imem_rsp_valid = vecs[i].rsv;
         imem_rsp_data  = vecs[i].rsd;
         inst_ready     = vecs[i].ir;
         #4;
         if (vecs[i].chk) begin
            check(vecs[i].name, i, "req_valid", 32'(imem_req_valid), 32'(vecs[i].e_rqv));
            if (vecs[i].e_rqv)
               check(vecs[i].name, i, "req_addr", imem_req_addr, vecs[i].e_rqa);
            check(vecs[i].name, i, "inst_valid", 32'(inst_valid), 32'(vecs[i].e_iv));
            if (vecs[i].e_iv || vecs[i].rst) begin
               check(vecs[i].name, i, "inst_pc", inst_pc, vecs[i].e_ipc);
               check(vecs[i].name, i, "inst_data", inst_data, vecs[i].e_idat);
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            check(vecs[i].name, i, "misaligned", 32'(fetch_misaligned), 32'(vecs[i].e_mis));
`endif
         end
         $display("row %0d %s: req_valid=%0b addr=%h inst_valid=%0b pc=%h data=%h",
                  i, vecs[i].name, imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data);
      end

      // ---------------- hand-written: stalled request, then redirected ----------------
      @(posedge clk); #1;
      drive_idle(); rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #4;
         check("stall", k, "req_valid", 32'(imem_req_valid), 32'd1);
         check("stall", k, "req_addr", imem_req_addr, 32'h0);
         $display("stall %0d: req_valid=%0b addr=%h", k, imem_req_valid, imem_req_addr);
         @(posedge clk); #1;
      end
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(posedge clk); #1;
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      #4;
      check("stall", 4, "req_valid", 32'(imem_req_valid), 32'd1);
      check("stall", 4, "req_addr", imem_req_addr, 32'h40);
      $display("stall redirect: req_valid=%0b addr=%h", imem_req_valid, imem_req_addr);
      @(posedge clk); #1;
      imem_req_ready = 1'b0;
      #4;
      check("stall", 5, "req_valid", 32'(imem_req_valid), 32'd0);
      $display("stall accepted: req_valid=%0b", imem_req_valid);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
